// File: rtl/start_scheduler_if.sv
// Handshake and configuration bundle between the start scheduler and its
// register block / event generators.
interface start_scheduler_if #(
    parameter int unsigned NumGenerators = 3,
    parameter int unsigned PeriodWidth   = 16,
    parameter int unsigned HoldoffWidth  = 8,
    parameter int unsigned CountWidth    = 32,
    parameter int unsigned BurstWidth    = 16
);
    logic                     start_ext;
    logic                     use_external;
    logic [PeriodWidth-1:0]   period;
    logic [HoldoffWidth-1:0]  holdoff;
    logic [BurstWidth-1:0]    burst_count;
    logic [NumGenerators-1:0] enable;
    logic                     arm;
    logic                     abort;
    logic [NumGenerators-1:0] busy;
    logic [NumGenerators-1:0] start;
    logic                     running;
    logic [CountWidth-1:0]    trigger_count;
    logic [CountWidth-1:0]    missed_count;

    modport master (
        output start_ext, use_external, period, holdoff, burst_count,
               enable, arm, abort, busy,
        input  start, running, trigger_count, missed_count
    );

    modport slave (
        input  start_ext, use_external, period, holdoff, burst_count,
               enable, arm, abort, busy,
        output start, running, trigger_count, missed_count
    );
endinterface

// File: rtl/start_scheduler.sv
// Start-strobe sequencer for the event generators: external or internal
// periodic trigger, per-trigger holdoff, busy-drop counting, bursts and abort.
module start_scheduler #(
    parameter int unsigned NumGenerators = 3,
    parameter int unsigned PeriodWidth   = 16,
    parameter int unsigned HoldoffWidth  = 8,
    parameter int unsigned CountWidth    = 32
) (
    input  logic               clk,
    input  logic               rst,
    start_scheduler_if.slave   bus
);
    localparam int unsigned SyncDepth = 3;

    typedef enum logic [1:0] {IDLE, RUN, HOLDOFF, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [SyncDepth-1:0]     sync_q;
    logic                     use_ext_q, use_ext_d;
    logic [NumGenerators-1:0] en_q, en_d;
    logic [NumGenerators-1:0] start_q, start_d;
    logic                     running_q, running_d;
    logic [CountWidth-1:0]    trig_cnt_q, trig_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [CountWidth-1:0]    trig_inc, miss_inc;
    logic [PeriodWidth-1:0]   per_q, per_d;
    logic [HoldoffWidth-1:0]  hold_q, hold_d;
    logic                     ext_edge, int_tick, trig, gen_busy, burst_done;

    // Trigger sources and saturating count increments
    always_comb begin
        ext_edge   = sync_q[1] & ~sync_q[2];
        int_tick   = (per_q == '0);
        trig       = use_ext_q ? ext_edge : int_tick;
        gen_busy   = |(bus.busy & en_q);
        trig_inc   = (&trig_cnt_q) ? trig_cnt_q : trig_cnt_q + 1'b1;
        miss_inc   = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
        burst_done = (bus.burst_count != '0) &&
                     (trig_inc == CountWidth'(bus.burst_count));
    end

    // Next-state and next-register logic
    always_comb begin
        state_d    = state_q;
        use_ext_d  = use_ext_q;
        en_d       = en_q;
        start_d    = '0;
        trig_cnt_d = trig_cnt_q;
        miss_cnt_d = miss_cnt_q;
        per_d      = per_q;
        hold_d     = hold_q;

        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    use_ext_d  = bus.use_external;
                    en_d       = bus.enable;
                    trig_cnt_d = '0;
                    miss_cnt_d = '0;
                    per_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = DRAIN;
                end else if (trig) begin
                    if (gen_busy) begin
                        miss_cnt_d = miss_inc;
                    end else begin
                        start_d    = en_q;
                        trig_cnt_d = trig_inc;
                        hold_d     = bus.holdoff;
                        state_d    = burst_done ? DRAIN : HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (bus.abort) begin
                    state_d = DRAIN;
                end else begin
                    if (trig) miss_cnt_d = miss_inc;
                    if (hold_q == '0) state_d = RUN;
                    else              hold_d  = hold_q - 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.abort && !gen_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Period counter only advances while triggers can occur
        if (state_q == RUN || state_q == HOLDOFF) begin
            per_d = (per_q >= bus.period) ? '0 : per_q + 1'b1;
        end

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            use_ext_q  <= 1'b0;
            en_q       <= '0;
            start_q    <= '0;
            running_q  <= 1'b0;
            trig_cnt_q <= '0;
            miss_cnt_q <= '0;
            per_q      <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SyncDepth-2:0], bus.start_ext};
            use_ext_q  <= use_ext_d;
            en_q       <= en_d;
            start_q    <= start_d;
            running_q  <= running_d;
            trig_cnt_q <= trig_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            per_q      <= per_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.start         = start_q;
    assign bus.running       = running_q;
    assign bus.trigger_count = trig_cnt_q;
    assign bus.missed_count  = miss_cnt_q;
endmodule

// File: tb/tb_start_scheduler.sv
// Self-checking bench for start_scheduler: vector table, hand-written corner
// sequences and randomized runs against a behavioural reference model.
module tb_start_scheduler;
    logic clk = 1'b0;
    logic rst;

    start_scheduler_if bus ();
    start_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_strobes = 0;

    // Reference model state
    bit         m_active, m_drain, m_use_ext;
    int         m_hold_left;
    longint     m_cycles, m_trig, m_miss;
    logic [2:0] m_en, m_start, m_hist;

    typedef struct {
        bit         use_ext;
        int         period;
        int         holdoff;
        int         burst;
        logic [2:0] en;
        logic [2:0] busy;
        int         steps;
        int         exp_strobes;
        int         exp_trig;
        int         exp_miss;
        bit         exp_running;
    } vec_t;

    vec_t vecs[6];

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_active = 0; m_drain = 0; m_use_ext = 0; m_hold_left = 0;
        m_cycles = 0; m_trig = 0; m_miss = 0;
        m_en = '0; m_start = '0; m_hist = '0;
    endfunction

    function automatic longint sat_inc(longint v);
        return (v >= 64'd4294967295) ? v : v + 1;
    endfunction

    // One clock edge of the specified behaviour
    function automatic void model_step();
        bit ext_edge;
        bit trig;
        ext_edge = m_hist[1] & ~m_hist[2];
        m_hist   = {m_hist[1:0], bus.start_ext};
        m_start  = '0;
        if (!m_active) begin
            if (bus.arm) begin
                m_active = 1; m_drain = 0; m_hold_left = 0;
                m_use_ext = bus.use_external; m_en = bus.enable;
                m_cycles = 0; m_trig = 0; m_miss = 0;
            end
        end else if (m_drain) begin
            if (!bus.abort && (bus.busy & m_en) == 3'b000) m_active = 0;
        end else begin
            trig = m_use_ext ? ext_edge
                             : ((m_cycles % (longint'(bus.period) + 1)) == 0);
            m_cycles++;
            if (bus.abort) begin
                m_drain = 1;
            end else if (m_hold_left > 0) begin
                if (trig) m_miss = sat_inc(m_miss);
                m_hold_left--;
            end else if (trig) begin
                if ((bus.busy & m_en) != 3'b000) begin
                    m_miss = sat_inc(m_miss);
                end else begin
                    m_start = m_en;
                    m_trig  = sat_inc(m_trig);
                    if (bus.burst_count != 16'd0 && m_trig == longint'(bus.burst_count))
                        m_drain = 1;
                    else
                        m_hold_left = int'(bus.holdoff) + 1;
                end
            end
        end
    endfunction

    function automatic void check_outputs();
        chk("start", longint'(bus.start), longint'(m_start));
        chk("running", longint'(bus.running), longint'(m_active));
        chk("trigger_count", longint'(bus.trigger_count), m_trig);
        chk("missed_count", longint'(bus.missed_count), m_miss);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (bus.start != 3'b000) n_strobes++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.start_ext = 1'b0; bus.busy = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic cfg(bit use_ext, int period, int holdoff, int burst, logic [2:0] en);
        bus.use_external = use_ext;
        bus.period       = 16'(period);
        bus.holdoff      = 8'(holdoff);
        bus.burst_count  = 16'(burst);
        bus.enable       = en;
    endtask

    task automatic arm_step();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    initial begin
        //          ext per hold burst en      busy    steps strb trig miss run
        vecs[0] = '{1'b0, 9, 0, 0, 3'b111, 3'b000, 41, 5, 5, 0, 1'b1};
        vecs[1] = '{1'b0, 4, 0, 3, 3'b111, 3'b000, 20, 3, 3, 0, 1'b0};
        vecs[2] = '{1'b0, 2, 4, 0, 3'b111, 3'b000, 19, 4, 4, 3, 1'b1};
        vecs[3] = '{1'b0, 3, 0, 0, 3'b000, 3'b111,  8, 0, 2, 0, 1'b1};
        vecs[4] = '{1'b0, 1, 0, 0, 3'b010, 3'b010,  6, 0, 0, 3, 1'b1};
        vecs[5] = '{1'b0, 0, 0, 0, 3'b101, 3'b010,  6, 3, 3, 3, 1'b1};

        rst = 1'b1;
        cfg(0, 0, 0, 0, '0);
        model_reset();
        do_reset();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            cfg(vecs[i].use_ext, vecs[i].period, vecs[i].holdoff, vecs[i].burst, vecs[i].en);
            bus.busy = vecs[i].busy;
            n_strobes = 0;
            arm_step();
            repeat (vecs[i].steps) step();
            chk($sformatf("vec%0d_strobes", i), n_strobes, vecs[i].exp_strobes);
            chk($sformatf("vec%0d_trig", i), longint'(bus.trigger_count), vecs[i].exp_trig);
            chk($sformatf("vec%0d_miss", i), longint'(bus.missed_count), vecs[i].exp_miss);
            chk($sformatf("vec%0d_running", i), longint'(bus.running), longint'(vecs[i].exp_running));
        end

        // Busy drop on the 2nd tick, disabled generator busy throughout
        do_reset();
        cfg(0, 4, 0, 0, 3'b001);
        n_strobes = 0;
        bus.busy = 3'b100;
        arm_step();
        for (int s = 1; s <= 20; s++) begin
            bus.busy = (s == 6) ? 3'b101 : 3'b100;
            step();
            if (s == 1) chk("busy_first_strobe", longint'(bus.start), 1);
            if (s == 6) chk("busy_dropped", longint'(bus.start), 0);
        end
        chk("busy_strobes", n_strobes, 3);
        chk("busy_missed", longint'(bus.missed_count), 1);

        // External trigger with long holdoff
        do_reset();
        cfg(1, 0, 49, 0, 3'b111);
        n_strobes = 0;
        arm_step();
        for (int s = 1; s <= 140; s++) begin
            bus.start_ext = (s >= 5 && s < 145 && ((s - 5) % 20) < 2);
            step();
            if (s == 7 || s == 67 || s == 127)
                chk($sformatf("ext_latency_%0d", s), longint'(bus.start), 7);
        end
        bus.start_ext = 1'b0;
        chk("ext_strobes", n_strobes, 3);
        chk("ext_missed", longint'(bus.missed_count), 4);

        // Abort coincident with a tick while a generator is busy
        do_reset();
        cfg(0, 4, 0, 0, 3'b111);
        arm_step();
        repeat (5) step();
        bus.busy = 3'b010;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_no_start", longint'(bus.start), 0);
        chk("abort_trig", longint'(bus.trigger_count), 1);
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("abort_drain_running_%0d", s), longint'(bus.running), 1);
        end
        bus.busy = 3'b000;
        step();
        chk("abort_idle", longint'(bus.running), 0);
        bus.abort = 1'b1;
        step();
        chk("abort_in_idle", longint'(bus.running), 0);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.abort = 1'b0;
        chk("arm_beats_abort", longint'(bus.running), 1);

        // Asynchronous reset during holdoff
        do_reset();
        cfg(0, 30, 20, 0, 3'b111);
        arm_step();
        step();
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_start", longint'(bus.start), 0);
        chk("rst_running", longint'(bus.running), 0);
        chk("rst_trigger_count", longint'(bus.trigger_count), 0);
        chk("rst_missed_count", longint'(bus.missed_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_strobes = 0;
        repeat (30) step();
        chk("rst_no_strobes", n_strobes, 0);
        chk("rst_stays_idle", longint'(bus.running), 0);

        // Randomized runs against the model
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            cfg(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 10),
                $urandom_range(0, 5), 3'($urandom));
            arm_step();
            for (int c = 0; c < 250; c++) begin
                bus.arm   = ($urandom_range(0, 99) < 4);
                bus.abort = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 99) < 20) bus.busy = 3'($urandom);
                if ($urandom_range(0, 99) < 15) bus.start_ext = ~bus.start_ext;
                step();
            end
            bus.arm = 1'b0; bus.abort = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/start_scheduler.md
Name: start_scheduler

Overview:
- Sequences the start strobes for the electron event generators (multi-spectrum and list-event).
- Selects either the external start input or an internal periodic trigger, and enforces a per-trigger holdoff.
- Drops and counts triggers that arrive while any enabled generator is still emitting.
- Supports finite bursts and abort; configuration and status connect to ApbWriteRegister/read registers in the top level.

Parameters:
- NumGenerators, 3, number of generators sequenced; width of enable_i, busy_i and start_o.
- PeriodWidth, 16, width of period_i.
- HoldoffWidth, 8, width of holdoff_i.
- CountWidth, 32, width of trigger_count_o and missed_count_o.

Ports:
- clk_i  in  1  fabric clock, 100 MHz.
- reset_i  in  1  asynchronous, active-high reset.
- start_ext_i  in  1  external start, asynchronous to clk_i.
- use_external_i  in  1  1 = external trigger source, 0 = internal; latched on arm.
- period_i  in  PeriodWidth  internal trigger period, in cycles minus 1.
- holdoff_i  in  HoldoffWidth  post-trigger holdoff, in cycles minus 1.
- burst_count_i  in  16  number of triggers per run; 0 = run continuously.
- enable_i  in  NumGenerators  per-generator enable; latched on arm.
- arm_i  in  1  single-cycle pulse that starts a run.
- abort_i  in  1  single-cycle pulse that ends a run.
- busy_i  in  NumGenerators  generator still emitting its event.
- start_o  out  NumGenerators  single-cycle start strobe per generator.
- running_o  out  1  high when state is not IDLE.
- trigger_count_o  out  CountWidth  triggers issued in the current run.
- missed_count_o  out  CountWidth  triggers dropped in the current run.

Behaviour:
- Reset:
  - state IDLE; all outputs 0; synchronizer FFs, period counter and holdoff counter 0.
  - Reset may assert in any state; outputs clear asynchronously.
- External path:
  - start_ext_i passes through 2 synchronizing FFs, then 1 edge FF; ext_edge = sync2 & ~sync3.
  - The synchronizer runs in every state. Edges are acted on only in RUN; edges in HOLDOFF are counted as missed; edges in IDLE or DRAIN are ignored.
- Internal path:
  - Period counter runs only while the state is RUN or HOLDOFF. It counts 0..period_i, then wraps to 0.
  - int_tick = (counter == 0). period_i = 0 gives a tick every cycle.
  - The counter is cleared on arm.
- trig = use_ext_q ? ext_edge : int_tick, where use_ext_q is latched at arm.
- IDLE:
  - On arm_i: latch use_external_i and enable_i, clear both counts and the period counter, go to RUN.
  - abort_i in IDLE has no effect.
- RUN, on trig:
  - If (busy_i & en_q) != 0: missed_count_o += 1; state stays RUN.
  - Otherwise: start_o <= en_q for exactly 1 cycle (registered), trigger_count_o += 1, load the holdoff counter, go to HOLDOFF.
  - If burst_count_i != 0 and the incremented trigger_count equals burst_count_i, go to DRAIN instead of HOLDOFF.
- HOLDOFF:
  - Lasts holdoff_i+1 cycles, then returns to RUN.
  - Any trig during HOLDOFF increments missed_count_o.
- DRAIN:
  - No triggers are accepted.
  - Go to IDLE on the first cycle with (busy_i & en_q) == 0, evaluated combinationally. The count values are held.
- abort_i in RUN, HOLDOFF or DRAIN: go to DRAIN.
  - abort_i has priority over a simultaneous trig: no start_o is issued and the trig is not counted.
- Simultaneous arm_i and abort_i in IDLE: arm wins.
- en_q = 0:
  - Triggers are still accepted and counted; start_o stays 0.
  - busy_i is ignored, because it is masked by en_q.
- Counters saturate at all-ones and do not wrap.
- Latency:
  - External: start_o is high during the cycle after the 3rd rising clk_i edge counting from the first edge that samples start_ext_i high.
  - Internal: start_o is high during the cycle after the 2nd clk_i edge counting from the edge that samples arm_i (edge 1 enters RUN with tick, edge 2 registers start_o).
- start_o never asserts on consecutive cycles.

Test Plan:
1. Internal continuous: period_i=9, holdoff_i=0, burst=0, en=3'b111, arm → start_o=3'b111 every 10 cycles; after 5 strobes trigger_count_o=5, missed=0.
2. Burst: burst_count_i=3, period_i=4, busy_i=0 → exactly 3 strobes, then running_o falls 1 cycle after the DRAIN entry; trigger_count_o holds 3.
3. Busy drop: en=3'b001, busy_i[0]=1 across the 2nd tick, busy_i[2]=1 throughout → 2nd trigger dropped, missed=1; busy_i[2] ignored on the other ticks.
4. External with holdoff: use_external_i=1, holdoff_i=49, start_ext_i pulses 20 cycles apart → only every 3rd pulse issues a strobe, each 3 cycles after its rise; the others increment missed.
5. Abort: abort_i coincident with a trig while busy_i=3'b010 (en=3'b111) → no start_o; running_o stays high until busy_i clears, then 0.
6. Reset mid-run: assert reset_i during HOLDOFF → all outputs 0 immediately; after release no strobes occur until arm_i.
